// File: rtl/decoder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decoder_pkg : shared constants and state encoding for the decoder scan path
// Rev 1.0
// ----------------------------------------------------------------------------
package decoder_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    localparam logic [2:0] EN_ON  = 3'b001;
    localparam logic [2:0] EN_OFF = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BLANK  = 2'd2
    } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/decoder_scan_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decoder_scan_ctrl_if : control/status bundle between host and scan sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
interface decoder_scan_ctrl_if
    import decoder_pkg::*;
#(
    parameter int DWELL_W = 16
);
    logic               start;
    logic               stop;
    logic               mode_cont;
    logic [N_CH-1:0]    ch_mask;
    logic [DWELL_W-1:0] dwell;
    logic [SEL_W-1:0]   sel;
    logic [2:0]         en;
    logic               busy;
    logic               sweep_done;
    logic               err_no_ch;

    modport master (
        output start, stop, mode_cont, ch_mask, dwell,
        input  sel, en, busy, sweep_done, err_no_ch
    );

    modport slave (
        input  start, stop, mode_cont, ch_mask, dwell,
        output sel, en, busy, sweep_done, err_no_ch
    );
endinterface
`default_nettype wire

// File: rtl/next_ch_find.sv
`default_nettype none
// ----------------------------------------------------------------------------
// next_ch_find : next set mask bit strictly above cur, else lowest set bit
// Rev 1.0
// ----------------------------------------------------------------------------
module next_ch_find
    import decoder_pkg::*;
(
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] cur,
    output logic [SEL_W-1:0] nxt,
    output logic             wrapped
);
    always_comb begin
        nxt     = '0;
        wrapped = 1'b1;
        // Downward scans: the last hit is the lowest qualifying bit.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i]) nxt = SEL_W'(i);
        end
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                nxt     = SEL_W'(i);
                wrapped = 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/decoder_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decoder_scan_ctrl : steps decoder_3to8 select through masked channels with dwell/blank
// Rev 1.0
// ----------------------------------------------------------------------------
module decoder_scan_ctrl
    import decoder_pkg::*;
#(
    parameter int DWELL_W      = 16,
    parameter int BLANK_CYCLES = 1
)(
    input  logic                clk,
    input  logic                rst_n,
    decoder_scan_ctrl_if.slave  bus
);
    localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES + 1) : 1;

    scan_state_e        state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [2:0]         en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [N_CH-1:0]    mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cont_q, cont_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [BLK_W-1:0]   blk_q, blk_d;

    logic [N_CH-1:0]    find_mask;
    logic [SEL_W-1:0]   find_cur;
    logic [SEL_W-1:0]   find_nxt;
    logic               find_wrapped;
    logic [DWELL_W-1:0] dwell_eff;
    logic               do_adv;

    // In IDLE, searching above the top channel yields the lowest set bit.
    assign find_mask = (state_q == ST_IDLE) ? bus.ch_mask : mask_q;
    assign find_cur  = (state_q == ST_IDLE) ? SEL_W'(N_CH - 1) : sel_q;
    assign dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

    next_ch_find u_find (
        .mask    (find_mask),
        .cur     (find_cur),
        .nxt     (find_nxt),
        .wrapped (find_wrapped)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        do_adv  = 1'b0;

        if (bus.stop) begin
            state_d = ST_IDLE;
            en_d    = EN_OFF;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.ch_mask == '0) begin
                            err_d = 1'b1;
                        end else begin
                            mask_d  = bus.ch_mask;
                            dwell_d = dwell_eff;
                            cont_d  = bus.mode_cont;
                            sel_d   = find_nxt;
                            cnt_d   = dwell_eff;
                            en_d    = EN_ON;
                            busy_d  = 1'b1;
                            state_d = ST_ACTIVE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (cnt_q <= DWELL_W'(1)) begin
                        if (BLANK_CYCLES > 0) begin
                            state_d = ST_BLANK;
                            en_d    = EN_OFF;
                            blk_d   = BLK_W'(BLANK_CYCLES);
                        end else begin
                            do_adv = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end
                end
                ST_BLANK: begin
                    if (blk_q <= BLK_W'(1)) do_adv = 1'b1;
                    else                    blk_d  = blk_q - BLK_W'(1);
                end
                default: begin
                    state_d = ST_IDLE;
                    en_d    = EN_OFF;
                    busy_d  = 1'b0;
                end
            endcase

            if (do_adv) begin
                done_d = find_wrapped;
                if (find_wrapped && !cont_q) begin
                    state_d = ST_IDLE;
                    en_d    = EN_OFF;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_ACTIVE;
                    sel_d   = find_nxt;
                    en_d    = EN_ON;
                    cnt_d   = dwell_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            en_q    <= EN_OFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mask_q  <= '0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
            cnt_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.en         = en_q;
    assign bus.busy       = busy_q;
    assign bus.sweep_done = done_q;
    assign bus.err_no_ch  = err_q;
endmodule
`default_nettype wire

// File: tb/tb_decoder_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_decoder_scan_ctrl : scan sequencer against an arithmetic schedule model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_decoder_scan_ctrl;
    import decoder_pkg::*;

    typedef struct {
        logic [2:0] sel;
        logic [2:0] en;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    decoder_scan_ctrl_if #(.DWELL_W(16)) if1 ();
    decoder_scan_ctrl_if #(.DWELL_W(16)) if0 ();

    decoder_scan_ctrl #(.DWELL_W(16), .BLANK_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    decoder_scan_ctrl #(.DWELL_W(16), .BLANK_CYCLES(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output expected k cycles after the start cycle: each channel takes
    // d active plus B blank cycles, a sweep is nch of those.
    function automatic exp_t model(int k, logic [7:0] m, int dw, bit cont, int b, int stop_at);
        exp_t e;
        int   d, nch, p, l, pos, idx, cnt;
        e = '{sel: 3'd0, en: 3'b000, busy: 1'b0, done: 1'b0, err: 1'b0};
        if (stop_at >= 0 && k > stop_at) return e;
        d   = (dw == 0) ? 1 : dw;
        nch = $countones(m);
        p   = d + b;
        l   = nch * p;
        if (!cont && k >= l) begin
            e.done = (k == l);
            return e;
        end
        pos = k % l;
        idx = pos / p;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                if (cnt == idx) e.sel = 3'(i);
                cnt++;
            end
        end
        e.en   = ((pos % p) < d) ? 3'b001 : 3'b000;
        e.busy = 1'b1;
        e.done = (k > 0) && (pos == 0);
        return e;
    endfunction

    task automatic chk(string tag, logic [2:0] sel, logic [2:0] en, logic busy,
                       logic done, logic err, exp_t e);
        vectors++;
        assert (en === e.en && busy === e.busy && done === e.done && err === e.err &&
                (!e.busy || sel === e.sel))
        else begin
            miscompares++;
            $error("FAIL %s: got sel=%0d en=%b busy=%b done=%b err=%b, want sel=%0d en=%b busy=%b done=%b err=%b",
                   tag, sel, en, busy, done, err, e.sel, e.en, e.busy, e.done, e.err);
        end
    endtask

    task automatic chk_both(string tag, exp_t e1, exp_t e0);
        chk({tag, "/B1"}, if1.sel, if1.en, if1.busy, if1.sweep_done, if1.err_no_ch, e1);
        chk({tag, "/B0"}, if0.sel, if0.en, if0.busy, if0.sweep_done, if0.err_no_ch, e0);
    endtask

    task automatic chk_reset(string tag);
        exp_t z;
        z = '{sel: 3'd0, en: 3'b000, busy: 1'b0, done: 1'b0, err: 1'b0};
        chk_both(tag, z, z);
        vectors++;
        assert (if1.sel === 3'd0 && if0.sel === 3'd0)
        else begin
            miscompares++;
            $error("FAIL %s_sel: got sel1=%0d sel0=%0d, want 0", tag, if1.sel, if0.sel);
        end
    endtask

    task automatic drive(bit st, bit sp, bit cont, logic [7:0] m, logic [15:0] dw);
        if1.start = st; if1.stop = sp; if1.mode_cont = cont; if1.ch_mask = m; if1.dwell = dw;
        if0.start = st; if0.stop = sp; if0.mode_cont = cont; if0.ch_mask = m; if0.dwell = dw;
    endtask

    // One start, ncyc checked cycles, optional stop after output index stop_at,
    // optional input churn and ignored start pulses while busy, then either a
    // closing stop or an asynchronous reset in the middle of the run.
    task automatic run(string tag, logic [7:0] m, int dw, bit cont, int ncyc,
                       int stop_at, bit noise, bit end_rst);
        exp_t e1, e0, z;
        bit   st;
        z = '{sel: 3'd0, en: 3'b000, busy: 1'b0, done: 1'b0, err: 1'b0};
        drive(1'b1, 1'b0, cont, m, 16'(dw));
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            e1 = model(k, m, dw, cont, 1, stop_at);
            e0 = model(k, m, dw, cont, 0, stop_at);
            chk_both(tag, e1, e0);
            st = noise && e1.busy && e0.busy && (stop_at < 0 || k <= stop_at) &&
                 ($urandom_range(0, 3) == 0);
            if (noise)
                drive(st, k == stop_at, 1'($urandom), 8'($urandom), 16'($urandom_range(0, 9)));
            else
                drive(1'b0, k == stop_at, cont, m, 16'(dw));
        end
        if (end_rst) begin
            #3 rst_n = 1'b0;
            #1 chk_reset({tag, "_async_rst"});
            @(posedge clk); #1;
            chk_reset({tag, "_rst_hold"});
            rst_n = 1'b1;
            drive(1'b0, 1'b0, 1'b0, 8'h00, 16'd0);
        end else begin
            drive(1'b0, 1'b1, 1'b0, 8'h00, 16'd0);
            @(posedge clk); #1;
            chk_both({tag, "_end_stop"}, z, z);
            drive(1'b0, 1'b0, 1'b0, 8'h00, 16'd0);
        end
    endtask

    initial begin
        exp_t z, ez;
        vectors     = 0;
        miscompares = 0;
        z  = '{sel: 3'd0, en: 3'b000, busy: 1'b0, done: 1'b0, err: 1'b0};
        ez = '{sel: 3'd0, en: 3'b000, busy: 1'b0, done: 1'b0, err: 1'b1};
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 16'd0);
        #2 chk_reset("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Empty mask: one-cycle error pulse, block never leaves idle.
        drive(1'b1, 1'b0, 1'b0, 8'h00, 16'd5);
        @(posedge clk); #1;
        chk_both("err_no_ch", ez, ez);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 16'd0);
        @(posedge clk); #1;
        chk_both("err_clear", z, z);

        run("full_single",  8'hFF, 2, 1'b0, 30, -1, 1'b0, 1'b0);
        run("sparse_cont",  8'hA4, 1, 1'b1, 20, -1, 1'b0, 1'b0);
        run("stop_sel3",    8'h0F, 6, 1'b0, 26, 22, 1'b0, 1'b0);

        // Start and stop together in idle: stop wins.
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 16'd3);
        @(posedge clk); #1;
        chk_both("start_stop", z, z);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 16'd0);
        @(posedge clk); #1;
        chk_both("start_stop_after", z, z);

        run("dwell0_cont",  8'h01, 0, 1'b1, 10, -1, 1'b0, 1'b1);
        run("midrun_churn", 8'h0F, 2, 1'b0, 20, -1, 1'b1, 1'b0);

        for (int r = 0; r < 12; r++) begin
            run("random", 8'($urandom_range(1, 255)), int'($urandom_range(0, 4)),
                1'($urandom), 40,
                ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 38)),
                1'b1, ($urandom_range(0, 5) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
